// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared word width, ALU operation encoding and helpers for the
//               single-bus datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int WORD_W = 32;

    // ALU operation select; explicit width so the encoding is stable.
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_INC = 2'd1,
        ALU_NEG = 2'd2
    } alu_op_e;

    // Widen a word to the Z register width, replicating the sign bit.
    function automatic logic [2*WORD_W-1:0] sign_extend(input logic [WORD_W-1:0] value);
        return {{WORD_W{value[WORD_W-1]}}, value};
    endfunction

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/datapath_alu.sv
`default_nettype none
// ============================================================================
// Module      : datapath_alu
// Description : Combinational ALU for the single-bus datapath. Computes
//               Y+bus, bus+1 or 0-bus, all wrapping modulo 2^WORD_W.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WORD_W-1:0] Y,
    input  logic [WORD_W-1:0] bus,
    input  alu_op_e           op,
    output logic [WORD_W-1:0] result
);

    localparam logic [WORD_W-1:0] c_one  = {{(WORD_W-1){1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0] c_zero = '0;

    // Select the arithmetic result; carries out of the top bit are dropped.
    always_comb begin
        result = Y + bus;
        unique case (op)
            ALU_ADD: result = Y + bus;
            ALU_INC: result = bus + c_one;
            ALU_NEG: result = c_zero - bus;
            default: result = Y + bus;
        endcase
    end

endmodule : datapath_alu
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module      : datapath
// Description : Single-bus register datapath. A priority bus mux feeds the
//               general registers, PC, IR, MAR, MDR, Y and the ALU; the ALU
//               result lands in the 64-bit Z register sign-extended.
//               Build option: define DATAPATH_NEG_EN to enable the NEG
//               (two's complement negate) ALU operation; otherwise the NEG
//               input is accepted but has no effect.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath
    import datapath_pkg::*;
(
    input  logic                PCout,
    input  logic                Zlowout,
    input  logic                MDRout,
    input  logic                R1out,
    input  logic                MARin,
    input  logic                Zin,
    input  logic                PCin,
    input  logic                MDRin,
    input  logic                IRin,
    input  logic                Yin,
    input  logic                IncPC,
    input  logic                Read,
    input  logic                NEG,
    input  logic                R0in,
    input  logic                R1in,
    input  logic                Clock,
    input  logic [WORD_W-1:0]   Mdatain,
    input  logic                R0out,
    input  logic                clear,
    output logic [WORD_W-1:0]   BusMuxOut,
    output logic [WORD_W-1:0]   R0_q,
    output logic [WORD_W-1:0]   R1_q,
    output logic [WORD_W-1:0]   PC_q,
    output logic [WORD_W-1:0]   IR_q,
    output logic [WORD_W-1:0]   MAR_q,
    output logic [WORD_W-1:0]   MDR_q,
    output logic [WORD_W-1:0]   Y_q,
    output logic [2*WORD_W-1:0] Z_q
);

    logic [WORD_W-1:0]   r_r0;
    logic [WORD_W-1:0]   r_r1;
    logic [WORD_W-1:0]   r_pc;
    logic [WORD_W-1:0]   r_ir;
    logic [WORD_W-1:0]   r_mar;
    logic [WORD_W-1:0]   r_mdr;
    logic [WORD_W-1:0]   r_y;
    logic [2*WORD_W-1:0] r_z;

    logic [WORD_W-1:0]   w_bus;
    logic [WORD_W-1:0]   w_alu_result;
    alu_op_e             w_alu_op;

    // Bus mux: fixed priority PC > Zlow > MDR > R0 > R1, idle bus reads zero.
    always_comb begin
        w_bus = '0;
        if (PCout)        w_bus = r_pc;
        else if (Zlowout) w_bus = r_z[WORD_W-1:0];
        else if (MDRout)  w_bus = r_mdr;
        else if (R0out)   w_bus = r_r0;
        else if (R1out)   w_bus = r_r1;
    end

`ifdef DATAPATH_NEG_EN
    // Operation decode: increment wins over negate, otherwise accumulate Y.
    always_comb begin
        w_alu_op = ALU_ADD;
        if (IncPC)    w_alu_op = ALU_INC;
        else if (NEG) w_alu_op = ALU_NEG;
    end
`else
    // NEG is kept on the port list for pin compatibility but is not decoded.
    logic w_unused_neg;
    assign w_unused_neg = NEG;

    // Operation decode without negate support.
    always_comb begin
        w_alu_op = ALU_ADD;
        if (IncPC) w_alu_op = ALU_INC;
    end
`endif

    datapath_alu u_alu (
        .Y      (r_y),
        .bus    (w_bus),
        .op     (w_alu_op),
        .result (w_alu_result)
    );

    // Register file update: clear beats every enable; all loads see the pre-edge bus.
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_r0  <= '0;
            r_r1  <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_z   <= '0;
        end else begin
            if (R0in)  r_r0  <= w_bus;
            if (R1in)  r_r1  <= w_bus;
            if (PCin)  r_pc  <= w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (MARin) r_mar <= w_bus;
            if (Yin)   r_y   <= w_bus;
            if (MDRin) r_mdr <= Read ? Mdatain : w_bus;
            if (Zin)   r_z   <= sign_extend(w_alu_result);
        end
    end

    assign BusMuxOut = w_bus;
    assign R0_q      = r_r0;
    assign R1_q      = r_r1;
    assign PC_q      = r_pc;
    assign IR_q      = r_ir;
    assign MAR_q     = r_mar;
    assign MDR_q     = r_mdr;
    assign Y_q       = r_y;
    assign Z_q       = r_z;

endmodule : datapath
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath
// Description : Self-checking bench for datapath. A transfer-level model
//               tracks every register; a negedge process compares the DUT
//               against it, and literal expectations pin key results.
//               Honours DATAPATH_NEG_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath;

`ifdef DATAPATH_NEG_EN
    localparam bit NEG_EN = 1'b1;
`else
    localparam bit NEG_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        clear, PCout, Zlowout, MDRout, R0out, R1out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, R0in, R1in;
    logic        IncPC, NEG, Read;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut, R0_q, R1_q, PC_q, IR_q, MAR_q, MDR_q, Y_q;
    logic [63:0] Z_q;

    datapath dut (
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R1out(R1out),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .IncPC(IncPC), .Read(Read), .NEG(NEG), .R0in(R0in),
        .R1in(R1in), .Clock(Clock), .Mdatain(Mdatain), .R0out(R0out),
        .clear(clear), .BusMuxOut(BusMuxOut), .R0_q(R0_q), .R1_q(R1_q),
        .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q),
        .Z_q(Z_q)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: register names mapped to their contents.
    logic [31:0] m_reg [string];
    logic [63:0] m_z;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_bus();
        if (PCout)   return m_reg["PC"];
        if (Zlowout) return m_z[31:0];
        if (MDRout)  return m_reg["MDR"];
        if (R0out)   return m_reg["R0"];
        if (R1out)   return m_reg["R1"];
        return 32'h0;
    endfunction

    task automatic idle();
        {clear, PCout, Zlowout, MDRout, R0out, R1out} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, R0in, R1in} = '0;
        {IncPC, NEG, Read} = '0;
        Mdatain = 32'h0;
    endtask

    // Advance one clock: derive the model's next state from the current
    // controls, then return at posedge+1 with controls cleared.
    task automatic step();
        logic [31:0]    b;
        longint         sum;
        logic [31:0]    res;
        logic [31:0]    nx [string];
        logic [63:0]    nz;
        b  = model_bus();
        nx = m_reg;
        nz = m_z;
        if (IncPC)              sum = longint'(b) + 1;
        else if (NEG_EN && NEG) sum = 64'h1_0000_0000 - longint'(b);
        else                    sum = longint'(m_reg["Y"]) + longint'(b);
        res = sum[31:0];
        if (clear) begin
            foreach (nx[k]) nx[k] = 32'h0;
            nz = 64'h0;
        end else begin
            if (R0in)  nx["R0"]  = b;
            if (R1in)  nx["R1"]  = b;
            if (PCin)  nx["PC"]  = b;
            if (IRin)  nx["IR"]  = b;
            if (MARin) nx["MAR"] = b;
            if (Yin)   nx["Y"]   = b;
            if (MDRin) nx["MDR"] = Read ? Mdatain : b;
            if (Zin)   nz = 64'($signed(res));
        end
        @(posedge Clock);
        #1;
        m_reg = nx;
        m_z   = nz;
        idle();
    endtask

    // Compare every visible output against the model once per cycle.
    always @(negedge Clock) begin
        if (chk_en) begin
            check("bus", {32'h0, BusMuxOut}, {32'h0, model_bus()});
            check("R0",  {32'h0, R0_q},  {32'h0, m_reg["R0"]});
            check("R1",  {32'h0, R1_q},  {32'h0, m_reg["R1"]});
            check("PC",  {32'h0, PC_q},  {32'h0, m_reg["PC"]});
            check("IR",  {32'h0, IR_q},  {32'h0, m_reg["IR"]});
            check("MAR", {32'h0, MAR_q}, {32'h0, m_reg["MAR"]});
            check("MDR", {32'h0, MDR_q}, {32'h0, m_reg["MDR"]});
            check("Y",   {32'h0, Y_q},   {32'h0, m_reg["Y"]});
            check("Z",   Z_q, m_z);
        end
    end

    // Bounded run time.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic load_mdr(input logic [31:0] v);
        MDRin = 1; Read = 1; Mdatain = v; step();
    endtask

    initial begin
        foreach (m_reg[k]) m_reg[k] = 32'h0;
        m_reg["R0"] = 0; m_reg["R1"] = 0; m_reg["PC"] = 0; m_reg["IR"] = 0;
        m_reg["MAR"] = 0; m_reg["MDR"] = 0; m_reg["Y"] = 0;
        m_z = 0;
        idle();
        clear = 1; MARin = 1; Zin = 1;
        step();
        chk_en = 1'b1;
        check("reset Z", Z_q, 64'h0);
        check("reset PC", {32'h0, PC_q}, 64'h0);

        // Memory load into R0 and R1.
        load_mdr(32'h12);
        MDRout = 1; R0in = 1; step();
        check("load R0", {32'h0, R0_q}, 64'h12);
        load_mdr(32'h14);
        MDRout = 1; R1in = 1; step();
        check("load R1", {32'h0, R1_q}, 64'h14);

        // Instruction fetch from PC=0.
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; step();
        check("fetch MAR", {32'h0, MAR_q}, 64'h0);
        check("fetch Zlow", {32'h0, Z_q[31:0]}, 64'h1);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h28918000; step();
        check("fetch PC", {32'h0, PC_q}, 64'h1);
        check("fetch MDR", {32'h0, MDR_q}, 64'h28918000);
        MDRout = 1; IRin = 1; step();
        check("fetch IR", {32'h0, IR_q}, 64'h28918000);

        // Negate R0 (plain Y+bus with Y=0 when negate is not built in).
        R0out = 1; NEG = 1; Zin = 1; step();
        check("neg Z", Z_q, NEG_EN ? 64'hFFFFFFFF_FFFFFFEE : 64'h12);
        Zlowout = 1; R0in = 1; step();
        check("neg R0", {32'h0, R0_q}, NEG_EN ? 64'hFFFFFFEE : 64'h12);

        // IncPC beats NEG.
        load_mdr(32'h5);
        MDRout = 1; IncPC = 1; NEG = 1; Zin = 1; step();
        check("inc prio", {32'h0, Z_q[31:0]}, 64'h6);

        // Bus priority plus simultaneous capture into Y and MAR.
        PCout = 1; MDRout = 1; Yin = 1; MARin = 1;
        #1;
        check("bus prio", {32'h0, BusMuxOut}, 64'h1);
        step();
        check("multi Y", {32'h0, Y_q}, 64'h1);
        check("multi MAR", {32'h0, MAR_q}, 64'h1);

        // Wrap: 0xFFFFFFFF + 1 -> 0.
        load_mdr(32'hFFFFFFFF);
        MDRout = 1; Yin = 1; step();
        load_mdr(32'h1);
        MDRout = 1; R1in = 1; step();
        R1out = 1; Zin = 1; step();
        check("wrap add", Z_q, 64'h0);

        // Negate of the most negative word.
        load_mdr(32'h80000000);
        MDRout = 1; NEG = 1; Zin = 1; step();
        check("neg min", Z_q, NEG_EN ? 64'hFFFFFFFF_80000000 : 64'h00000000_7FFFFFFF);

        // Z drives the bus and reloads in the same cycle: pre-edge value used.
        Zlowout = 1; Zin = 1; step();
        R1out = 1; R1in = 1; Yin = 1; step();
        check("self load R1", {32'h0, R1_q}, 64'h1);
        step();

        // Clear in the middle of an operation.
        load_mdr(32'hA5A5A5A5);
        MDRout = 1; clear = 1; Zin = 1; R0in = 1; PCin = 1; step();
        check("clear R0", {32'h0, R0_q}, 64'h0);
        check("clear Z", Z_q, 64'h0);
        check("clear MDR", {32'h0, MDR_q}, 64'h0);
        step();
        @(negedge Clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_datapath
`default_nettype wire
